vec_mem_seq: RTL and testbench
==============================

VEC_MEM_SEQ -- requirements
Module: vec_mem_seq

Interface
REQ-001 Parameter LANES, 4, number of vector lanes (power of two, 2..8).
REQ-002 Parameter DW, 8, lane/scalar data width in bits.
REQ-003 Parameter AW, 16, word-address width.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 valid_in  in  1  execute-stage op present.
REQ-007 cl_mem_op  in  2  00 none, 01 scalar access, 10 vector access, 11 reserved.
REQ-008 cl_mem_st  in  1  1 store, 0 load.
REQ-009 base_addr  in  AW  word address of lane 0 or scalar word.
REQ-010 vec_wdata  in  LANES*DW  store data; lane i at bits [i*DW +: DW].
REQ-011 esc_wdata  in  DW  scalar store data.
REQ-012 mem_req  out  1  memory request.
REQ-013 mem_we  out  1  write strobe, qualified by mem_req.
REQ-014 mem_addr  out  AW  request address.
REQ-015 mem_wdata  out  DW  write data.
REQ-016 mem_rdata  in  DW  read data, valid with mem_ready.
REQ-017 mem_ready  in  1  beat completes when mem_req and mem_ready are both high at posedge.
REQ-018 stall  out  1  freezes upstream pipeline registers (drives their en low).
REQ-019 vec_rdata  out  LANES*DW  vector load result.
REQ-020 esc_rdata  out  DW  scalar load result.
REQ-021 done  out  1  one-cycle completion pulse.
REQ-022 err  out  1  one-cycle pulse on reserved op.

Function
REQ-023 FSM states IDLE, ACCESS, DONE; nothing else reachable.
REQ-024 IDLE: valid_in and cl_mem_op in {01,10} -> start: latch op, st, base_addr, write data; lane counter = 0; next ACCESS.
REQ-025 IDLE: valid_in and cl_mem_op=11 -> err high next cycle for one cycle, state stays IDLE, no memory request.
REQ-026 IDLE with cl_mem_op=00 or valid_in low: no action.
REQ-027 stall is combinational: high in the start cycle and in every ACCESS cycle, low in IDLE (non-start) and DONE.
REQ-028 ACCESS: mem_req=1; mem_we = latched st; mem_addr = (latched base + lane) mod 2^AW; mem_wdata = lane slice of latched vec_wdata (vector) or latched esc_wdata (scalar).
REQ-029 Beat count: scalar 1, vector LANES; lane increments on each completed beat only.
REQ-030 mem_ready low holds request, address and data stable; no timeout.
REQ-031 Load beat: mem_rdata captured into vec_rdata lane slot (vector) or esc_rdata (scalar) on the completing edge.
REQ-032 Last beat completes -> DONE; DONE: done=1, stall=0, next IDLE unconditionally.
REQ-033 Inputs are ignored in ACCESS and DONE; new ops are accepted only in IDLE.
REQ-034 vec_rdata/esc_rdata hold their value until overwritten by a later load; stores do not modify them.
REQ-035 Address wrap: base near 2^AW wraps to 0 (e.g. AW=16, base 0xFFFE, LANES 4 -> FFFE, FFFF, 0000, 0001).
REQ-036 Minimum latency with mem_ready tied high: vector op start cycle + LANES ACCESS cycles + 1 DONE cycle.

Reset
REQ-037 reset high at posedge -> state IDLE, lane 0, latched fields 0, vec_rdata 0, esc_rdata 0, done 0, err 0.
REQ-038 Reset mid-ACCESS aborts the op: mem_req, mem_we, stall low from the following cycle; no done pulse; partial load data discarded (0).
REQ-039 reset has priority over start on the same edge.

Verification
REQ-040 Vector load, base 0x0010, mem_ready=1, rdata = 0xA0+addr[3:0] -> addrs 10..13, stall 5 cycles, done once, vec_rdata = 0xA3A2A1A0.
REQ-041 Vector store, base 0x0020, vec_wdata 0x44332211, ready low 2 cycles on beat 1 -> wdata 11,22,22,22,33,44, addr held at 0x0021 while stalled, done after 6 ACCESS cycles.
REQ-042 Scalar load base 0x0005, rdata 0x5A -> one beat, esc_rdata 0x5A, vec_rdata unchanged.
REQ-043 Wrap: vector store base 0xFFFE -> addrs FFFE, FFFF, 0000, 0001.
REQ-044 cl_mem_op=11 with valid_in -> err one cycle, mem_req never high, stall low.
REQ-045 Reset asserted after beat 2 of a vector load -> mem_req 0 next cycle, no done, vec_rdata 0.

Source files
------------

// File: rtl/vec_mem_seq_if.sv
// Single-beat memory request bus: a beat completes when mem_req and mem_ready are both high at posedge.
// The sequencer drives the request through the master modport; the memory answers through the slave modport.
interface vec_mem_seq_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/vec_mem_seq.sv
// Vector/scalar memory sequencer: one bus beat per lane, stalling the upstream pipe until the op retires.
// Latency: start cycle + one ACCESS cycle per beat + one DONE cycle; mem_ready low holds the beat and keeps stall high.
module vec_mem_seq #(
    parameter int LANES = 4,
    parameter int DW    = 8,
    parameter int AW    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [1:0]            cl_mem_op,
    input  logic                  cl_mem_st,
    input  logic [AW-1:0]         base_addr,
    input  logic [LANES*DW-1:0]   vec_wdata,
    input  logic [DW-1:0]         esc_wdata,
    vec_mem_seq_if.master         mem,
    output logic                  stall,
    output logic [LANES*DW-1:0]   vec_rdata,
    output logic [DW-1:0]         esc_rdata,
    output logic                  done,
    output logic                  err
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [1:0] OP_SCALAR = 2'b01;
    localparam logic [1:0] OP_VECTOR = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [LW-1:0]         lane_q, lane_d;
    logic                  vec_q, vec_d;
    logic                  st_q, st_d;
    logic [AW-1:0]         base_q, base_d;
    logic [LANES*DW-1:0]   vwd_q, vwd_d;
    logic [DW-1:0]         swd_q, swd_d;
    logic [LANES*DW-1:0]   vrd_q, vrd_d;
    logic [DW-1:0]         erd_q, erd_d;
    logic                  err_q, err_d;

    logic start;
    logic last_beat;

    always_comb begin
        start     = (state_q == IDLE) && valid_in &&
                    ((cl_mem_op == OP_SCALAR) || (cl_mem_op == OP_VECTOR));
        last_beat = !vec_q || (lane_q == LW'(LANES - 1));
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        vec_d   = vec_q;
        st_d    = st_q;
        base_d  = base_q;
        vwd_d   = vwd_q;
        swd_d   = swd_q;
        vrd_d   = vrd_q;
        erd_d   = erd_q;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCESS;
                    lane_d  = '0;
                    vec_d   = (cl_mem_op == OP_VECTOR);
                    st_d    = cl_mem_st;
                    base_d  = base_addr;
                    vwd_d   = vec_wdata;
                    swd_d   = esc_wdata;
                end else if (valid_in && (cl_mem_op == OP_RSVD)) begin
                    err_d = 1'b1;
                end
            end
            ACCESS: begin
                // Lane only advances on a completed beat, so a stalled beat keeps addr/data stable.
                if (mem.mem_ready) begin
                    if (!st_q) begin
                        if (vec_q) begin
                            vrd_d[int'(lane_q) * DW +: DW] = mem.mem_rdata;
                        end else begin
                            erd_d = mem.mem_rdata;
                        end
                    end
                    if (last_beat) begin
                        state_d = DONE;
                    end else begin
                        lane_d = lane_q + LW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lane_q  <= '0;
            vec_q   <= 1'b0;
            st_q    <= 1'b0;
            base_q  <= '0;
            vwd_q   <= '0;
            swd_q   <= '0;
            vrd_q   <= '0;
            erd_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            vec_q   <= vec_d;
            st_q    <= st_d;
            base_q  <= base_d;
            vwd_q   <= vwd_d;
            swd_q   <= swd_d;
            vrd_q   <= vrd_d;
            erd_q   <= erd_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        mem.mem_req   = (state_q == ACCESS);
        mem.mem_we    = (state_q == ACCESS) && st_q;
        mem.mem_addr  = base_q + AW'(lane_q);
        mem.mem_wdata = vec_q ? vwd_q[int'(lane_q) * DW +: DW] : swd_q;
        stall         = start || (state_q == ACCESS);
        done          = (state_q == DONE);
        err           = err_q;
        vec_rdata     = vrd_q;
        esc_rdata     = erd_q;
    end
endmodule

// File: tb/tb_vec_mem_seq.sv
// Randomized self-checking bench for vec_mem_seq against a beat-level reference model.
module tb_vec_mem_seq;
    localparam int LANES = 4;
    localparam int DW    = 8;
    localparam int AW    = 16;
    localparam int VW    = LANES * DW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          valid_in = 1'b0;
    logic [1:0]    cl_mem_op = 2'b00;
    logic          cl_mem_st = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [VW-1:0] vec_wdata = '0;
    logic [DW-1:0] esc_wdata = '0;
    logic          stall;
    logic [VW-1:0] vec_rdata;
    logic [DW-1:0] esc_rdata;
    logic          done;
    logic          err;

    vec_mem_seq_if #(.AW(AW), .DW(DW)) mif ();

    vec_mem_seq #(.LANES(LANES), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .cl_mem_op (cl_mem_op),
        .cl_mem_st (cl_mem_st),
        .base_addr (base_addr),
        .vec_wdata (vec_wdata),
        .esc_wdata (esc_wdata),
        .mem       (mif),
        .stall     (stall),
        .vec_rdata (vec_rdata),
        .esc_rdata (esc_rdata),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Memory model: read data is a keyed function of the address.
    logic [DW-1:0] rd_key = '0;
    logic          ready_r = 1'b1;
    int            ready_mode = 0;
    int            hold_cnt = 0;
    assign mif.mem_rdata = mif.mem_addr[DW-1:0] ^ rd_key;
    assign mif.mem_ready = ready_r;

    int            mon_stall = 0;
    int            mon_done = 0;
    int            mon_err = 0;
    int            mon_beats = 0;
    logic [AW-1:0] cyc_addr[$];
    logic [DW-1:0] cyc_wdata[$];
    logic          cyc_we[$];
    logic          cyc_rdy[$];

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            1: ready_r = ($urandom_range(0, 2) != 0);
            2: begin
                if (mif.mem_req && mon_beats == 1 && hold_cnt < 2) begin
                    ready_r = 1'b0;
                    hold_cnt++;
                end else begin
                    ready_r = 1'b1;
                end
            end
            default: ready_r = 1'b1;
        endcase
    end

    always @(negedge clk) begin
        if (stall) mon_stall++;
        if (done) mon_done++;
        if (err) mon_err++;
        if (mif.mem_req) begin
            cyc_addr.push_back(mif.mem_addr);
            cyc_wdata.push_back(mif.mem_wdata);
            cyc_we.push_back(mif.mem_we);
            cyc_rdy.push_back(mif.mem_ready);
            if (mif.mem_ready) mon_beats++;
        end
    end

    // Reference model of the load result registers.
    logic [DW-1:0] exp_vrd[LANES];
    logic [DW-1:0] exp_erd;
    int            lat;
    bit            timed_out;

    function automatic logic [VW-1:0] pack_vrd();
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < LANES; i++) v[i*DW +: DW] = exp_vrd[i];
        return v;
    endfunction

    task automatic clear_mon();
        mon_stall = 0;
        mon_done  = 0;
        mon_err   = 0;
        mon_beats = 0;
        cyc_addr.delete();
        cyc_wdata.delete();
        cyc_we.delete();
        cyc_rdy.delete();
    endtask

    // Issues one op, scribbles random inputs while busy, returns after DONE plus settle idle cycles.
    task automatic do_op(input logic [1:0] op, input logic st, input logic [AW-1:0] base,
                         input logic [VW-1:0] vw, input logic [DW-1:0] sw,
                         input int mode, input int settle);
        logic [AW-1:0] a;
        ready_mode = mode;
        hold_cnt   = 0;
        clear_mon();
        valid_in  = 1'b1;
        cl_mem_op = op;
        cl_mem_st = st;
        base_addr = base;
        vec_wdata = vw;
        esc_wdata = sw;
        timed_out = 1'b0;
        @(posedge clk); #1;
        lat = 1;
        while (!done) begin
            if (lat > 200) begin
                timed_out = 1'b1;
                break;
            end
            valid_in  = 1'($urandom_range(0, 1));
            cl_mem_op = 2'($urandom_range(0, 3));
            cl_mem_st = 1'($urandom_range(0, 1));
            base_addr = AW'($urandom);
            vec_wdata = VW'($urandom);
            esc_wdata = DW'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        valid_in  = 1'b0;
        cl_mem_op = 2'b00;
        @(posedge clk); #1;
        repeat (settle) begin
            @(posedge clk); #1;
        end
        if (!st) begin
            if (op == 2'b10) begin
                for (int i = 0; i < LANES; i++) begin
                    a = base + AW'(i);
                    exp_vrd[i] = a[DW-1:0] ^ rd_key;
                end
            end else begin
                exp_erd = base[DW-1:0] ^ rd_key;
            end
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        valid_in  = 1'b1;
        cl_mem_op = 2'b10;
        base_addr = 16'h1234;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (mif.mem_req !== 1'b0) $display("FAIL rst_priority_req: got %b want 0", mif.mem_req); else n_pass++;
        valid_in  = 1'b0;
        cl_mem_op = 2'b00;
        reset     = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (mif.mem_req !== 1'b0 || stall !== 1'b0) $display("FAIL rst_idle: req=%b stall=%b want 0/0", mif.mem_req, stall); else n_pass++;
        n_checks++;
        if (done !== 1'b0 || err !== 1'b0) $display("FAIL rst_pulses: done=%b err=%b want 0/0", done, err); else n_pass++;
        n_checks++;
        if (vec_rdata !== '0 || esc_rdata !== '0) $display("FAIL rst_rdata: vec=%h esc=%h want 0/0", vec_rdata, esc_rdata); else n_pass++;
        for (int i = 0; i < LANES; i++) exp_vrd[i] = '0;
        exp_erd = '0;
    endtask

    task automatic test_vec_load();
        rd_key = 8'hB0;
        do_op(2'b10, 1'b0, 16'h0010, 32'h0, 8'h0, 0, 1);
        n_checks++;
        if (timed_out !== 1'b0 || lat !== LANES + 1) $display("FAIL vl_latency: got %0d (timeout %b) want %0d", lat, timed_out, LANES + 1); else n_pass++;
        n_checks++;
        if (cyc_addr.size() !== 4 || cyc_addr[0] !== 16'h0010 || cyc_addr[1] !== 16'h0011 ||
            cyc_addr[2] !== 16'h0012 || cyc_addr[3] !== 16'h0013)
            $display("FAIL vl_addrs: got %0d beats first %h want 0010..0013", cyc_addr.size(), cyc_addr.size() > 0 ? cyc_addr[0] : 16'hx);
        else n_pass++;
        n_checks++;
        if (mon_stall !== 5 || mon_done !== 1) $display("FAIL vl_stall_done: stall=%0d done=%0d want 5/1", mon_stall, mon_done); else n_pass++;
        n_checks++;
        if (vec_rdata !== 32'hA3A2A1A0) $display("FAIL vl_rdata: got %h want a3a2a1a0", vec_rdata); else n_pass++;
    endtask

    task automatic test_vec_store_hold();
        logic [DW-1:0] exp_wd[6] = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h44};
        bit bad;
        do_op(2'b10, 1'b1, 16'h0020, 32'h44332211, 8'h0, 2, 1);
        n_checks++;
        if (cyc_wdata.size() !== 6 || lat !== 7) $display("FAIL vs_cycles: got %0d access, lat %0d want 6/7", cyc_wdata.size(), lat); else n_pass++;
        bad = 1'b0;
        for (int k = 0; k < 6 && k < cyc_wdata.size(); k++) if (cyc_wdata[k] !== exp_wd[k] || cyc_we[k] !== 1'b1) bad = 1'b1;
        n_checks++;
        if (bad !== 1'b0) $display("FAIL vs_wdata: got bad=%b want sequence 11,22,22,22,33,44 with we", bad); else n_pass++;
        bad = 1'b0;
        for (int k = 1; k < 4 && k < cyc_addr.size(); k++) if (cyc_addr[k] !== 16'h0021) bad = 1'b1;
        n_checks++;
        if (bad !== 1'b0) $display("FAIL vs_addr_hold: got bad=%b want 0021 held", bad); else n_pass++;
        n_checks++;
        if (mon_done !== 1 || vec_rdata !== pack_vrd()) $display("FAIL vs_done_rdata: done=%0d vec=%h want 1/%h", mon_done, vec_rdata, pack_vrd()); else n_pass++;
    endtask

    task automatic test_scalar_load();
        rd_key = 8'h5F;
        do_op(2'b01, 1'b0, 16'h0005, 32'hDEADBEEF, 8'h77, 0, 1);
        n_checks++;
        if (esc_rdata !== 8'h5A) $display("FAIL sl_rdata: got %h want 5a", esc_rdata); else n_pass++;
        n_checks++;
        if (vec_rdata !== 32'hA3A2A1A0) $display("FAIL sl_vec_hold: got %h want a3a2a1a0", vec_rdata); else n_pass++;
        n_checks++;
        if (cyc_addr.size() !== 1 || lat !== 2 || mon_stall !== 2) $display("FAIL sl_beats: got %0d beats lat %0d stall %0d want 1/2/2", cyc_addr.size(), lat, mon_stall); else n_pass++;
    endtask

    task automatic test_wrap();
        do_op(2'b10, 1'b1, 16'hFFFE, VW'($urandom), 8'h0, 0, 1);
        n_checks++;
        if (cyc_addr.size() !== 4 || cyc_addr[0] !== 16'hFFFE || cyc_addr[1] !== 16'hFFFF ||
            cyc_addr[2] !== 16'h0000 || cyc_addr[3] !== 16'h0001)
            $display("FAIL wrap_addrs: got %0d beats last %h want fffe,ffff,0000,0001", cyc_addr.size(), cyc_addr.size() > 0 ? cyc_addr[cyc_addr.size()-1] : 16'hx);
        else n_pass++;
    endtask

    task automatic test_reserved();
        clear_mon();
        ready_mode = 0;
        valid_in   = 1'b1;
        cl_mem_op  = 2'b11;
        cl_mem_st  = 1'b1;
        @(posedge clk); #1;
        valid_in  = 1'b0;
        cl_mem_op = 2'b00;
        n_checks++;
        if (err !== 1'b1) $display("FAIL rsv_err_next: got %b want 1", err); else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (err !== 1'b0) $display("FAIL rsv_err_once: got %b want 0", err); else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (mon_err !== 1 || cyc_addr.size() !== 0 || mon_stall !== 0)
            $display("FAIL rsv_quiet: err=%0d req_cycles=%0d stall=%0d want 1/0/0", mon_err, cyc_addr.size(), mon_stall);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_op(2'b10, 1'b1, 16'h0040, 32'hCAFEF00D, 8'h0, 0, 0);
        n_checks++;
        if (mon_beats !== LANES || mon_done !== 1) $display("FAIL b2b_first: beats=%0d done=%0d want %0d/1", mon_beats, mon_done, LANES); else n_pass++;
        rd_key = 8'h69;
        do_op(2'b10, 1'b0, 16'h0080, 32'h0, 8'h0, 0, 1);
        n_checks++;
        if (lat !== LANES + 1 || mon_done !== 1) $display("FAIL b2b_second: lat=%0d done=%0d want %0d/1", lat, mon_done, LANES + 1); else n_pass++;
        n_checks++;
        if (vec_rdata !== pack_vrd()) $display("FAIL b2b_rdata: got %h want %h", vec_rdata, pack_vrd()); else n_pass++;
    endtask

    task automatic test_random();
        logic [1:0]    op;
        logic          st;
        logic [AW-1:0] base;
        logic [AW-1:0] exp_a;
        logic [VW-1:0] vw;
        logic [DW-1:0] sw;
        logic [DW-1:0] exp_w;
        int            n;
        int            b;
        bit            bad;
        for (int t = 0; t < 24; t++) begin
            op   = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            st   = 1'($urandom_range(0, 1));
            base = (t % 6 == 0) ? AW'(16'hFFFF - 16'($urandom_range(0, 2))) : AW'($urandom);
            vw   = VW'($urandom);
            sw   = DW'($urandom);
            rd_key = DW'($urandom);
            do_op(op, st, base, vw, sw, $urandom_range(0, 1), $urandom_range(0, 2));
            n = (op == 2'b10) ? LANES : 1;
            n_checks++;
            if (timed_out !== 1'b0 || mon_beats !== n) $display("FAIL rnd_beats[%0d]: got %0d (timeout %b) want %0d", t, mon_beats, timed_out, n); else n_pass++;
            b   = 0;
            bad = 1'b0;
            foreach (cyc_addr[k]) begin
                exp_a = base + AW'(b);
                exp_w = (op == 2'b10) ? vw[(b % LANES)*DW +: DW] : sw;
                if (b >= n || cyc_addr[k] !== exp_a || cyc_wdata[k] !== exp_w || cyc_we[k] !== st) bad = 1'b1;
                if (cyc_rdy[k]) b++;
            end
            n_checks++;
            if (bad !== 1'b0) $display("FAIL rnd_bus[%0d]: got bad=%b over %0d cycles want addr/wdata/we per model", t, bad, cyc_addr.size()); else n_pass++;
            n_checks++;
            if (mon_done !== 1 || mon_err !== 0 || mon_stall !== cyc_addr.size() + 1)
                $display("FAIL rnd_ctrl[%0d]: done=%0d err=%0d stall=%0d want 1/0/%0d", t, mon_done, mon_err, mon_stall, cyc_addr.size() + 1);
            else n_pass++;
            n_checks++;
            if (vec_rdata !== pack_vrd() || esc_rdata !== exp_erd)
                $display("FAIL rnd_rdata[%0d]: vec=%h esc=%h want %h/%h", t, vec_rdata, esc_rdata, pack_vrd(), exp_erd);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        rd_key = 8'h3C;
        ready_mode = 0;
        clear_mon();
        valid_in  = 1'b1;
        cl_mem_op = 2'b10;
        cl_mem_st = 1'b0;
        base_addr = 16'h0100;
        @(posedge clk); #1;
        valid_in  = 1'b0;
        cl_mem_op = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (mon_beats !== 2 || mif.mem_req !== 1'b1) $display("FAIL rm_setup: beats=%0d req=%b want 2/1", mon_beats, mif.mem_req); else n_pass++;
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (mif.mem_req !== 1'b0 || mif.mem_we !== 1'b0 || stall !== 1'b0)
            $display("FAIL rm_abort: req=%b we=%b stall=%b want 0/0/0", mif.mem_req, mif.mem_we, stall);
        else n_pass++;
        n_checks++;
        if (vec_rdata !== '0 || esc_rdata !== '0) $display("FAIL rm_rdata: vec=%h esc=%h want 0/0", vec_rdata, esc_rdata); else n_pass++;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (mon_done !== 0 || mif.mem_req !== 1'b0) $display("FAIL rm_no_done: done=%0d req=%b want 0/0", mon_done, mif.mem_req); else n_pass++;
        for (int i = 0; i < LANES; i++) exp_vrd[i] = '0;
        exp_erd = '0;
    endtask

    initial begin
        test_reset();
        test_vec_load();
        test_vec_store_hold();
        test_scalar_load();
        test_wrap();
        test_reserved();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
